instr_fetch: RTL

Instruction fetch unit: the initiator side of the instruction-memory read port. Owns the program counter and presents a word address to instruction memory every cycle it has room. Pairs each returned word with its PC and hands it to decode over a valid/ready handshake. Execute can redirect the PC for branches; in-flight and buffered wrong-path words are discarded.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_buffer.sv | 54 +++++
 rtl/instr_fetch.sv | 81 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, reset default and the buffered fetch entry type for the
// instruction fetch unit.
package fetch_pkg;
  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0]  RESET_PC_DEF = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR    = 32'hA800_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry shift FIFO of {pc, instr}; the head always lives in slot 0 so the
// output is a plain register read.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t [1:0] mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem   <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          mem[count[0]] <= din;
          count         <= count + 2'd1;
        end
        2'b01: begin
          mem[0] <= mem[1];
          count  <= count - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever survives the pop.
          if (count == 2'd1) begin
            mem[0] <= din;
          end else begin
            mem[0] <= mem[1];
            mem[1] <= din;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && count == 2'd2));
  end

  assign head = mem[0];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, keeps one read in flight against a
// registered instruction memory and buffers returned words for decode.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter int                BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic              inflight_q;

  logic         pop, push, room, issue;
  logic [1:0]   count;
  logic [2:0]   occ;
  fetch_entry_t head, din;

  assign out_valid = (count != 2'd0) && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign push      = inflight_q && !redirect_valid;

  // Occupancy once this cycle settles: buffered + returning - leaving.
  assign occ   = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign room  = occ < 3'(BUF_DEPTH);
  assign issue = fetch_en && room && !rst;

  always_comb begin
    imem_addr = pc_q;
    if (rst)                 imem_addr = RESET_PC;
    else if (redirect_valid) imem_addr = redirect_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (redirect_valid) begin
      pc_q          <= redirect_target + 32'd1;
      inflight_pc_q <= redirect_target;
      inflight_q    <= 1'b1;
    end else if (issue) begin
      pc_q          <= pc_q + 32'd1;
      inflight_pc_q <= pc_q;
      inflight_q    <= 1'b1;
    end else begin
      inflight_q    <= 1'b0;
    end
  end

  assign din.pc    = inflight_pc_q;
  assign din.instr = imem_instr;

  fetch_buffer u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect_valid),
    .din   (din),
    .head  (head),
    .count (count)
  );

  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule
